// File: rtl/enc_pkg.sv
// Shared types, opcode constants, immediate limits and field-packing helpers
// for the RV32I instruction encoder.
package enc_pkg;

    typedef enum logic [3:0] {
        LOAD   = 4'd0,
        STORE  = 4'd1,
        OP     = 4'd2,
        BRANCH = 4'd3,
        OPIMM  = 4'd4,
        JAL    = 4'd5,
        JALR   = 4'd6,
        AUIPC  = 4'd7,
        LUI    = 4'd8,
        LI     = 4'd9,
        FENCE  = 4'd10,
        ECALL  = 4'd11,
        EBREAK = 4'd12
    } enc_kind_t;

    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam int I_MIN     = -2048;
    localparam int I_MAX     = 2047;
    localparam int SHAMT_MAX = 31;
    localparam int B_MIN     = -4096;
    localparam int B_MAX     = 4094;
    localparam int J_MIN     = -(1 << 20);
    localparam int J_MAX     = (1 << 20) - 2;

    function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                          input logic [2:0] f3, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm, rs1, f3, rd, opc};
    endfunction

    function automatic logic [31:0] enc_s(input logic [11:0] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[11:5], rs2, rs1, f3, imm[4:0], opc};
    endfunction

    // Bit 0 of a branch offset is implied zero, so only [12:1] is packed.
    function automatic logic [31:0] enc_b(input logic [12:1] imm, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [6:0] opc);
        return {imm[12], imm[10:5], rs2, rs1, f3, imm[4:1], imm[11], opc};
    endfunction

    function automatic logic [31:0] enc_u(input logic [19:0] hi, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {hi, rd, opc};
    endfunction

    function automatic logic [31:0] enc_j(input logic [20:1] imm, input logic [4:0] rd,
                                          input logic [6:0] opc);
        return {imm[20], imm[10:1], imm[11], imm[19:12], rd, opc};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [4:0] rs2,
                                          input logic [4:0] rs1, input logic [2:0] f3,
                                          input logic [4:0] rd, input logic [6:0] opc);
        return {f7, rs2, rs1, f3, rd, opc};
    endfunction

endpackage

// File: rtl/enc_fifo.sv
// Synchronous circular-buffer FIFO with a registered head word; no
// push-through-pop bypass, pushes while full and pops while empty are ignored.
module enc_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         push,
    input  logic [W-1:0] wdata,
    input  logic         pop,
    output logic         full,
    output logic         empty,
    output logic [W-1:0] head
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] CNT_FULL = (AW + 1)'(DEPTH);
    localparam logic [AW:0] CNT_ONE  = (AW + 1)'(1);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] rd_ptr_next;
    logic [AW:0]   count_reg;
    logic [W-1:0]  head_reg;
    logic          do_push;
    logic          do_pop;

    assign full        = (count_reg == CNT_FULL);
    assign empty       = (count_reg == '0);
    assign do_push     = push && !full;
    assign do_pop      = pop && !empty;
    assign rd_ptr_next = rd_ptr_reg + 1'b1;
    assign head        = head_reg;

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr_reg] <= wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
            head_reg   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (do_pop) begin
                rd_ptr_reg <= rd_ptr_next;
            end
            case ({do_push, do_pop})
                2'b10:   count_reg <= count_reg + CNT_ONE;
                2'b01:   count_reg <= count_reg - CNT_ONE;
                default: count_reg <= count_reg;
            endcase
            // Head tracks the oldest entry: next stored word on pop, or the
            // incoming word when it becomes the only entry.
            if (do_pop) begin
                if (count_reg > CNT_ONE) begin
                    head_reg <= mem[rd_ptr_next];
                end else if (do_push) begin
                    head_reg <= wdata;
                end
            end else if (do_push && empty) begin
                head_reg <= wdata;
            end
        end
    end

endmodule

// File: rtl/instr_encoder.sv
// RV32I field-level instruction encoder with LI expansion and output FIFO.
// Define ENC_SYSTEM_EN to enable the FENCE/ECALL/EBREAK kinds.
module instr_encoder
    import enc_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [3:0]       req_kind,
    input  logic [2:0]       req_funct3,
    input  logic             req_funct7b5,
    input  logic [4:0]       req_rd,
    input  logic [4:0]       req_rs1,
    input  logic [4:0]       req_rs2,
    input  logic [31:0]      req_imm,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_instr,
    output logic [ERR_W-1:0] err_count
);
    localparam logic [0:0] IDLE   = 1'b0;
    localparam logic [0:0] SECOND = 1'b1;

    logic [0:0]       state_reg;
    logic [4:0]       rd_reg;
    logic [11:0]      lo_reg;
    logic [ERR_W-1:0] err_count_reg;

    logic             full;
    logic             empty;
    logic             accept;
    logic             push;
    logic [31:0]      push_word;

    logic [31:0]        enc_word;
    logic               enc_ok;
    logic               enc_second;
    logic signed [31:0] imm_s;
    logic               in_i;
    logic [19:0]        li_hi;

    assign req_ready = (state_reg == IDLE) && !full && !reset;
    assign accept    = req_valid && req_ready;
    assign imm_s     = req_imm;
    assign in_i      = (imm_s >= I_MIN) && (imm_s <= I_MAX);
    // (imm + 0x800) >> 12 is imm[31:12] plus the carry out of imm[11:0] + 0x800.
    assign li_hi     = req_imm[31:12] + {19'd0, req_imm[11]};

    always_comb begin
        enc_word   = '0;
        enc_ok     = 1'b0;
        enc_second = 1'b0;
        case (req_kind)
            LOAD: begin
                enc_ok   = in_i;
                enc_word = enc_i(req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_LOAD);
            end
            STORE: begin
                enc_ok   = in_i;
                enc_word = enc_s(req_imm[11:0], req_rs2, req_rs1, req_funct3, OPC_STORE);
            end
            OP: begin
                enc_ok   = 1'b1;
                enc_word = enc_r({1'b0, req_funct7b5, 5'd0}, req_rs2, req_rs1, req_funct3,
                                 req_rd, OPC_OP);
            end
            BRANCH: begin
                enc_ok   = (imm_s >= B_MIN) && (imm_s <= B_MAX) && !req_imm[0];
                enc_word = enc_b(req_imm[12:1], req_rs2, req_rs1, req_funct3, OPC_BRANCH);
            end
            OPIMM: begin
                if (req_funct3 == 3'b001 || req_funct3 == 3'b101) begin
                    enc_ok   = (imm_s >= 0) && (imm_s <= SHAMT_MAX);
                    enc_word = enc_i({1'b0, req_funct7b5, 5'd0, req_imm[4:0]}, req_rs1,
                                     req_funct3, req_rd, OPC_OPIMM);
                end else begin
                    enc_ok   = in_i;
                    enc_word = enc_i(req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_OPIMM);
                end
            end
            JAL: begin
                enc_ok   = (imm_s >= J_MIN) && (imm_s <= J_MAX) && !req_imm[0];
                enc_word = enc_j(req_imm[20:1], req_rd, OPC_JAL);
            end
            JALR: begin
                enc_ok   = in_i;
                enc_word = enc_i(req_imm[11:0], req_rs1, req_funct3, req_rd, OPC_JALR);
            end
            AUIPC: begin
                enc_ok   = (req_imm[11:0] == 12'd0);
                enc_word = enc_u(req_imm[31:12], req_rd, OPC_AUIPC);
            end
            LUI: begin
                enc_ok   = (req_imm[11:0] == 12'd0);
                enc_word = enc_u(req_imm[31:12], req_rd, OPC_LUI);
            end
            LI: begin
                enc_ok = 1'b1;
                if (in_i) begin
                    enc_word = enc_i(req_imm[11:0], 5'd0, 3'b000, req_rd, OPC_OPIMM);
                end else begin
                    enc_word   = enc_u(li_hi, req_rd, OPC_LUI);
                    enc_second = (req_imm[11:0] != 12'd0);
                end
            end
`ifdef ENC_SYSTEM_EN
            FENCE: begin
                enc_ok   = 1'b1;
                enc_word = 32'h0FF0_000F;
            end
            ECALL: begin
                enc_ok   = 1'b1;
                enc_word = 32'h0000_0073;
            end
            EBREAK: begin
                enc_ok   = 1'b1;
                enc_word = 32'h0010_0073;
            end
`endif
            default: begin
                enc_ok   = 1'b0;
                enc_word = '0;
            end
        endcase
    end

    assign push      = (state_reg == IDLE) ? (accept && enc_ok) : !full;
    assign push_word = (state_reg == IDLE) ? enc_word
                                           : enc_i(lo_reg, rd_reg, 3'b000, rd_reg, OPC_OPIMM);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= IDLE;
            rd_reg        <= '0;
            lo_reg        <= '0;
            err_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        if (!enc_ok) begin
                            if (err_count_reg != '1) begin
                                err_count_reg <= err_count_reg + 1'b1;
                            end
                        end else if (enc_second) begin
                            state_reg <= SECOND;
                            rd_reg    <= req_rd;
                            lo_reg    <= req_imm[11:0];
                        end
                    end
                end
                default: begin
                    if (!full) begin
                        state_reg <= IDLE;
                    end
                end
            endcase
        end
    end

    assign err_count = err_count_reg;

    enc_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (32)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .wdata (push_word),
        .pop   (out_ready),
        .full  (full),
        .empty (empty),
        .head  (out_instr)
    );

    assign out_valid = !empty;

endmodule

// File: tb/tb_instr_encoder.sv
// Scoreboard bench for instr_encoder: stimulus queues expected words, a
// monitor pops and compares each word the DUT hands out.
module tb_instr_encoder;
    import enc_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [3:0]  req_kind;
    logic [2:0]  req_funct3;
    logic        req_funct7b5;
    logic [4:0]  req_rd;
    logic [4:0]  req_rs1;
    logic [4:0]  req_rs2;
    logic [31:0] req_imm;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [7:0]  err_count;

    int          nvec = 0;
    int          nfail = 0;
    int          exp_err = 0;
    logic [31:0] exp_q[$];

    instr_encoder #(.FIFO_DEPTH(4), .ERR_W(8)) dut (
        .clk          (clk),
        .reset        (reset),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_kind     (req_kind),
        .req_funct3   (req_funct3),
        .req_funct7b5 (req_funct7b5),
        .req_rd       (req_rd),
        .req_rs1      (req_rs1),
        .req_rs2      (req_rs2),
        .req_imm      (req_imm),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_instr    (out_instr),
        .err_count    (err_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got 0x%08h want 0x%08h", name, act, exp);
        end else begin
            $display("ok   %s: 0x%08h", name, act);
        end
    endtask

    // Monitor: a word leaves the FIFO on the next edge when valid && ready.
    initial begin
        forever begin
            @(negedge clk);
            if (out_valid && out_ready && !reset) begin
                if (exp_q.size() == 0) begin
                    nvec++;
                    nfail++;
                    $display("FAIL unexpected_word: got 0x%08h want none", out_instr);
                end else begin
                    check("word", out_instr, exp_q.pop_front());
                end
            end
        end
    end

    task automatic send(input logic [3:0] k, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic f7,
                        input logic [31:0] imm);
        int n;
        req_kind = k; req_rd = rd; req_rs1 = rs1; req_rs2 = rs2;
        req_funct3 = f3; req_funct7b5 = f7; req_imm = imm; req_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (req_ready) break;
            n++;
            if (n > 200) begin
                nvec++; nfail++;
                $display("FAIL accept_timeout: got req_ready=0 want 1");
                break;
            end
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        req_imm   = 32'hDEAD_BEEF;
        req_rd    = 5'd31;
    endtask

    task automatic reject(input logic [3:0] k, input logic [31:0] imm);
        send(k, 5'd1, 5'd1, 5'd2, 3'b000, 1'b0, imm);
        if (exp_err < 255) exp_err++;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(posedge clk);
            n++;
        end
        #1;
        check("drained", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; req_valid = 1'b0; out_ready = 1'b0;
        req_kind = '0; req_funct3 = '0; req_funct7b5 = 1'b0;
        req_rd = '0; req_rs1 = '0; req_rs2 = '0; req_imm = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_instr", out_instr, 32'd0);
        check("rst_err", 32'(err_count), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0; out_ready = 1'b1;

        // ADDI x1,x0,5 and one-cycle latency
        exp_q.push_back(32'h0050_0093);
        send(OPIMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        check("latency_valid", 32'(out_valid), 32'd1);
        check("err_zero", 32'(err_count), 32'd0);
        drain();

        // LI needing LUI+ADDI; req_ready low exactly one cycle
        exp_q.push_back(32'h1234_52B7);
        exp_q.push_back(32'h6782_8293);
        send(LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5678);
        check("li_ready_low", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        check("li_ready_back", 32'(req_ready), 32'd1);
        drain();

        exp_q.push_back(32'h0000_10B7);
        exp_q.push_back(32'h8000_8093);
        send(LI, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0000_0800);
        drain();
        exp_q.push_back(32'h0000_10B7);
        send(LI, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'h0000_1000);
        check("li_lo_zero_idle", 32'(req_ready), 32'd1);
        drain();

        // Assorted formats
        exp_q.push_back(32'h0020_8463);
        send(BRANCH, 5'd0, 5'd1, 5'd2, 3'b000, 1'b0, 32'd8);
        exp_q.push_back(32'h0020_A223);
        send(STORE, 5'd0, 5'd1, 5'd2, 3'b010, 1'b0, 32'd4);
        exp_q.push_back(32'h0080_00EF);
        send(JAL, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd8);
        exp_q.push_back(32'hABCD_E1B7);
        send(LUI, 5'd3, 5'd0, 5'd0, 3'b000, 1'b0, 32'hABCD_E000);
        exp_q.push_back(32'h4020_81B3);
        send(OP, 5'd3, 5'd1, 5'd2, 3'b000, 1'b1, 32'd0);
        drain();

        // Rejections and saturation
        reject(BRANCH, 32'd4097);
        check("err_branch", 32'(err_count), 32'(exp_err));
        reject(4'd13, 32'd0);
        check("err_undef_kind", 32'(err_count), 32'(exp_err));
`ifdef ENC_SYSTEM_EN
        exp_q.push_back(32'h0FF0_000F);
        send(FENCE, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'd0);
        drain();
`else
        reject(FENCE, 32'd0);
        check("err_fence_off", 32'(err_count), 32'(exp_err));
`endif
        while (exp_err < 255) reject(LUI, 32'h0000_0001);
        check("err_sat", 32'(err_count), 32'd255);
        reject(JAL, 32'd3);
        check("err_hold", 32'(err_count), 32'd255);
        check("reject_no_word", 32'(out_valid), 32'd0);

        // Fill FIFO, then pulse out_ready while a fifth request waits
        out_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            exp_q.push_back(32'h0000_0093 | (32'(i) << 20));
            send(OPIMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'(i));
        end
        check("full_ready_low", 32'(req_ready), 32'd0);
        exp_q.push_back(32'h0050_0093);
        req_kind = OPIMM; req_rd = 5'd1; req_rs1 = 5'd0; req_funct3 = 3'b000;
        req_funct7b5 = 1'b0; req_imm = 32'd5; req_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        check("full_pop_blocks", 32'(req_ready), 32'd0);
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        check("after_pop_ready", 32'(req_ready), 32'd1);
        @(posedge clk); #1;
        req_valid = 1'b0;
        out_ready = 1'b1;
        drain();

        // Reset while the ADDI half of an LI is pending
        out_ready = 1'b0;
        send(LI, 5'd5, 5'd0, 5'd0, 3'b000, 1'b0, 32'h1234_5678);
        check("pre_rst_second", 32'(req_ready), 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_mid_li_valid", 32'(out_valid), 32'd0);
        exp_err = 0;
        check("rst_mid_li_err", 32'(err_count), 32'(exp_err));
        reset = 1'b0;
        @(negedge clk);
        check("rst_mid_li_idle", 32'(req_ready), 32'd1);
        out_ready = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        check("no_pending_addi", 32'(out_valid), 32'd0);
        exp_q.push_back(32'h0050_0093);
        send(OPIMM, 5'd1, 5'd0, 5'd0, 3'b000, 1'b0, 32'd5);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
        $finish;
    end

endmodule
